// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared state encodings and channel count
package mux_scan_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_CH = 4;
  localparam int CH_W   = $clog2(NUM_CH);

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - control, mux feedback and capture bundle
interface mux_scan_sequencer_if;
  import mux_scan_sequencer_pkg::*;

  logic              start;
  logic              stop;
  logic              continuous;
  logic              mux_out;
  logic              s0;
  logic              s1;
  logic [NUM_CH-1:0] sample;
  logic              frame_done;
  logic              busy;

  modport master (
    output start, stop, continuous, mux_out,
    input  s0, s1, sample, frame_done, busy
  );

  modport slave (
    input  start, stop, continuous, mux_out,
    output s0, s1, sample, frame_done, busy
  );

endinterface

// File: rtl/mux_scan_sequencer_dwell_timer.sv
// rtl/mux_scan_sequencer_dwell_timer.sv - per-channel dwell counter, last on DWELL-1
module dwell_timer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - walks a 4:1 mux select and captures each channel per frame
module mux_scan_sequencer
  import mux_scan_sequencer_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mux_scan_sequencer_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [CH_W-1:0]   ch;
  logic [NUM_CH-2:0] shadow;
  logic [NUM_CH-1:0] sample_q;
  logic              last;
  logic              capture;
  logic              frame_end;

  // stop outranks every capture, so an aborted frame never touches sample
  assign capture   = (state == SCAN) && last && !bus.stop;
  assign frame_end = capture && (ch == CH_W'(NUM_CH - 1));

  dwell_timer #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clear ((state != SCAN) || last),
    .en    (state == SCAN),
    .last  (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && !bus.stop) state_nxt = SCAN;
      SCAN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (frame_end) begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = (bus.continuous && !bus.stop) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s0         = 1'b0;
    bus.s1         = 1'b0;
    bus.busy       = 1'b0;
    bus.frame_done = 1'b0;
    case (state)
      SCAN: begin
        {bus.s1, bus.s0} = ch;
        bus.busy         = 1'b1;
      end
      DONE: begin
        {bus.s1, bus.s0} = 2'b11;
        bus.busy         = 1'b1;
        bus.frame_done   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch <= '0;
    end else if ((state != SCAN) || bus.stop) begin
      ch <= '0;
    end else if (last) begin
      ch <= ch + CH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      sample_q <= '0;
    end else if (frame_end) begin
      sample_q <= {bus.mux_out, shadow};
    end else if (capture) begin
      shadow[ch] <= bus.mux_out;
    end
  end

  assign bus.sample = sample_q;

endmodule
